neuron_act: RTL and testbench

NEURON_ACT -- requirements
Module: neuron_act

---
 rtl/neuron_act_if.sv | 24 ++
 rtl/neuron_act.sv | 134 +++++++++++++
 tb/tb_neuron_act.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/neuron_act_if.sv
// Stream bundle for neuron_act: accumulator beats in, activated words out.
// slave is the neuron_act side, master is the driver/consumer side.
interface neuron_act_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      s_axis_tvalid;
  logic [2*DATA_WIDTH-1:0]   s_axis_tdata;
  logic [DATA_WIDTH-1:0]     bias;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [DATA_WIDTH-1:0]     m_axis_tdata;
  logic                      m_axis_tlast;
  logic                      overflow;

  modport master (
    output s_axis_tvalid, s_axis_tdata, bias, m_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, overflow
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, bias, m_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast, overflow
  );
endinterface

// File: rtl/neuron_act.sv
// Neuron activation: bias add, rounded requantize with saturation, activation, FWFT output FIFO.
// Define NEURON_ACT_RELU_EN to select ReLU; otherwise the activation is identity.
module neuron_act #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_NEURONS = 16,
  parameter int FRAC_SHIFT  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  neuron_act_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int BW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0] BEAT_LAST = BW'(NUM_INPUTS - 1);
  localparam logic [NW-1:0] NEUR_LAST = NW'(NUM_NEURONS - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  localparam logic signed [2*W+1:0] RND     = $signed((2*W+2)'(1) << (FRAC_SHIFT - 1));
  localparam logic signed [2*W+1:0] SAT_MAX = $signed({{(W+3){1'b0}}, {(W-1){1'b1}}});
  localparam logic signed [2*W+1:0] SAT_MIN = $signed({{(W+3){1'b1}}, {(W-1){1'b0}}});

  logic [BW-1:0]          beatCnt_q;
  logic                   capValid_q;
  logic signed [2*W-1:0]  capSum_q;
  logic signed [W-1:0]    capBias_q;
  logic                   s1Valid_q;
  logic signed [2*W:0]    s1Sum_q, s1Sum_d;
  logic                   s2Valid_q;
  logic signed [W-1:0]    s2Sat_q, s2Sat_d;
  logic [NW-1:0]          neurCnt_q;
  logic [AW:0]            wrPtr_q, rdPtr_q;
  logic                   overflow_q;
  logic [W:0]             mem_q [FIFO_DEPTH];

  logic signed [2*W+1:0]  rounded, shifted;
  logic [W-1:0]           actData;
  logic [AW:0]            fifoCount;
  logic                   fifoEmpty, fifoFull, pop, push, drop;
  logic [W:0]             rdEntry;

  // Full-width arithmetic so neither the bias add nor the rounding offset can wrap.
  always_comb begin
    s1Sum_d = $signed({capSum_q[2*W-1], capSum_q}) + $signed({{(W+1){capBias_q[W-1]}}, capBias_q});
    rounded = $signed({s1Sum_q[2*W], s1Sum_q}) + RND;
    shifted = rounded >>> FRAC_SHIFT;
    s2Sat_d = shifted[W-1:0];
    if (shifted > SAT_MAX) begin
      s2Sat_d = SAT_MAX[W-1:0];
    end else if (shifted < SAT_MIN) begin
      s2Sat_d = SAT_MIN[W-1:0];
    end
  end

  always_comb begin
`ifdef NEURON_ACT_RELU_EN
    actData = s2Sat_q[W-1] ? '0 : s2Sat_q;
`else
    actData = s2Sat_q;
`endif
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    fifoCount = wrPtr_q - rdPtr_q;
    fifoEmpty = (wrPtr_q == rdPtr_q);
    fifoFull  = (fifoCount == FIFO_FULL);
    pop       = !fifoEmpty && bus.m_axis_tready;
    push      = s2Valid_q && (!fifoFull || pop);
    drop      = s2Valid_q && fifoFull && !pop;
    rdEntry   = mem_q[rdPtr_q[AW-1:0]];
  end

  assign bus.m_axis_tvalid = !fifoEmpty;
  assign bus.m_axis_tdata  = fifoEmpty ? '0 : rdEntry[W-1:0];
  assign bus.m_axis_tlast  = !fifoEmpty && rdEntry[W];
  assign bus.overflow      = overflow_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beatCnt_q  <= '0;
      capValid_q <= 1'b0;
      capSum_q   <= '0;
      capBias_q  <= '0;
      s1Valid_q  <= 1'b0;
      s1Sum_q    <= '0;
      s2Valid_q  <= 1'b0;
      s2Sat_q    <= '0;
      neurCnt_q  <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      capValid_q <= 1'b0;
      if (bus.s_axis_tvalid) begin
        if (beatCnt_q == BEAT_LAST) begin
          beatCnt_q  <= '0;
          capValid_q <= 1'b1;
          capSum_q   <= $signed(bus.s_axis_tdata);
          capBias_q  <= $signed(bus.bias);
        end else begin
          beatCnt_q <= beatCnt_q + 1'b1;
        end
      end
      s1Valid_q <= capValid_q;
      s1Sum_q   <= s1Sum_d;
      s2Valid_q <= s1Valid_q;
      s2Sat_q   <= s2Sat_d;
      // Dropped results still occupy a neuron slot so tlast stays layer-aligned.
      if (s2Valid_q) begin
        neurCnt_q <= (neurCnt_q == NEUR_LAST) ? '0 : neurCnt_q + 1'b1;
      end
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q[AW-1:0]] <= {(neurCnt_q == NEUR_LAST), actData};
    end
  end
endmodule

// File: tb/tb_neuron_act.sv
// Scoreboard bench for neuron_act: directed neurons push expected words, a monitor pops on each transfer.
module tb_neuron_act;
  localparam int DW = 32;
  localparam int NI = 4;
  localparam int NN = 4;
  localparam int FD = 4;
  localparam int FS = 16;

`ifdef NEURON_ACT_RELU_EN
  localparam logic [DW-1:0] EXP_NEG2   = 32'h0000_0000;
  localparam logic [DW-1:0] EXP_NEG1   = 32'h0000_0000;
  localparam logic [DW-1:0] EXP_NEGSAT = 32'h0000_0000;
`else
  localparam logic [DW-1:0] EXP_NEG2   = 32'hFFFF_FFFE;
  localparam logic [DW-1:0] EXP_NEG1   = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] EXP_NEGSAT = 32'h8000_0000;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  neuron_act_if #(.DATA_WIDTH(DW)) busIf ();

  neuron_act #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI),
    .NUM_NEURONS(NN),
    .FRAC_SHIFT (FS),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (busIf.slave)
  );

  int checks = 0;
  int errors = 0;
  int neurIdx = 0;
  int outCount = 0;
  logic [DW:0] expQ[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Monitor: every transfer pops the oldest expected word.
  always @(negedge clk) begin
    logic [DW:0] exp;
    if (reset_n && busIf.m_axis_tvalid && busIf.m_axis_tready) begin
      outCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWord actual=0x%0h required=none", busIf.m_axis_tdata);
      end else begin
        exp = expQ.pop_front();
        checkOutput("outData", 64'(busIf.m_axis_tdata), 64'(exp[DW-1:0]));
        checkOutput("outLast", 64'(busIf.m_axis_tlast), 64'(exp[DW]));
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] lastSum, input logic [31:0] lastBias,
                               input logic [31:0] expData, input bit gaps, input bit dropIt);
    for (int i = 0; i < NI; i++) begin
      if (gaps) begin
        busIf.s_axis_tvalid = 1'b0;
        busIf.s_axis_tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        busIf.bias          = 32'h7777_7777;
        @(posedge clk); #1;
      end
      busIf.s_axis_tvalid = 1'b1;
      busIf.s_axis_tdata  = (i == NI - 1) ? lastSum : (64'h1234_5678_0000_0000 | 64'(i));
      busIf.bias          = (i == NI - 1) ? lastBias : (32'h0F00_0000 | 32'(i));
      @(posedge clk); #1;
    end
    busIf.s_axis_tvalid = 1'b0;
    busIf.s_axis_tdata  = 64'hCAFE_CAFE_CAFE_CAFE;
    busIf.bias          = 32'h5555_5555;
    if (!dropIt) expQ.push_back({(neurIdx == NN - 1), expData});
    neurIdx = (neurIdx == NN - 1) ? 0 : neurIdx + 1;
  endtask

  task automatic waitDrain(input string name);
    for (int c = 0; c < 200 && expQ.size() != 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput(name, 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    busIf.s_axis_tvalid = 1'b0;
    busIf.s_axis_tdata  = '0;
    busIf.bias          = '0;
    busIf.m_axis_tready = 1'b1;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", 64'(busIf.m_axis_tvalid), 64'd0);
    checkOutput("rstData", 64'(busIf.m_axis_tdata), 64'd0);
    checkOutput("rstLast", 64'(busIf.m_axis_tlast), 64'd0);
    checkOutput("rstOverflow", 64'(busIf.overflow), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 3.5 rounds up to 4; valid appears exactly three edges after capture.
    applyStimulus(64'h0000_0000_0003_8000, 32'h0, 32'h0000_0004, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("latencyLow", 64'(busIf.m_axis_tvalid), 64'd0);
    end
    @(negedge clk);
    checkOutput("latencyHigh", 64'(busIf.m_axis_tvalid), 64'd1);
    waitDrain("drainA");

    applyStimulus(-64'sh2_0000, 32'h0, EXP_NEG2, 1'b0, 1'b0);
    applyStimulus(64'h0001_0000_0000_0000, 32'h0001_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    applyStimulus(64'h0000_0001_0000_0000, 32'h0, 32'h0001_0000, 1'b0, 1'b0);
    applyStimulus(64'hFFFF_0000_0000_0000, 32'h0, EXP_NEGSAT, 1'b0, 1'b0);
    waitDrain("drainB");

    // Back-to-back neurons, one with idle gaps between beats.
    applyStimulus(64'h0000_0000_0001_7FFF, 32'h0000_8000, 32'h0000_0002, 1'b0, 1'b0);
    applyStimulus(64'h0, 32'hFFFF_0000, EXP_NEG1, 1'b1, 1'b0);
    applyStimulus(64'h0000_0000_0000_8000, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
    waitDrain("drainC");

    // Stall the output: four words held, the fifth dropped.
    busIf.m_axis_tready = 1'b0;
    @(negedge clk);
    checkOutput("ovfBefore", 64'(busIf.overflow), 64'd0);
    @(posedge clk); #1;
    for (int k = 10; k < 15; k++) begin
      applyStimulus(64'(k) << 16, 32'h0, 32'(k), 1'b0, (k == 14));
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("ovfSet", 64'(busIf.overflow), 64'd1);
    checkOutput("heldValid", 64'(busIf.m_axis_tvalid), 64'd1);
    checkOutput("heldData", 64'(busIf.m_axis_tdata), 64'd10);
    @(posedge clk); #1;
    busIf.m_axis_tready = 1'b1;
    waitDrain("drainOvf");

    // Partial neuron discarded by a one-cycle reset.
    for (int i = 0; i < 2; i++) begin
      busIf.s_axis_tvalid = 1'b1;
      busIf.s_axis_tdata  = 64'h0000_0000_0009_0000;
      busIf.bias          = 32'h0;
      @(posedge clk); #1;
    end
    busIf.s_axis_tvalid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    neurIdx = 0;
    @(negedge clk);
    checkOutput("rstOvfClear", 64'(busIf.overflow), 64'd0);
    checkOutput("rstValid2", 64'(busIf.m_axis_tvalid), 64'd0);
    base = outCount;
    applyStimulus(64'h0000_0000_0005_0000, 32'h0, 32'h0000_0005, 1'b0, 1'b0);
    waitDrain("drainR1");
    repeat (4) @(negedge clk);
    checkOutput("oneOutput", 64'(outCount - base), 64'd1);
    applyStimulus(64'h0000_0000_0006_0000, 32'h0, 32'h0000_0006, 1'b0, 1'b0);
    applyStimulus(64'h0000_0000_0007_0000, 32'h0, 32'h0000_0007, 1'b0, 1'b0);
    applyStimulus(64'h0000_0000_0008_0000, 32'h0, 32'h0000_0008, 1'b0, 1'b0);
    waitDrain("drainR2");
    repeat (5) @(negedge clk);
    checkOutput("totalAfterReset", 64'(outCount - base), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
